// File: rtl/statefull_flow_table.sv
// Per-flow stateful match-action stage: DEPTH-entry state table indexed by a packet
// key field, updated by a two-stage read-modify-write pipeline with write-back forwarding.
module statefull_flow_table #(
    parameter int unsigned DATA_W   = 512,
    parameter int unsigned STATE_W  = 8,
    parameter int unsigned ACTION_W = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned KEY_LSB  = 0,
    parameter int unsigned THRESH   = 3,
    parameter int unsigned MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_vld_in,
    input  logic [DATA_W-1:0]   pkt_data_in,
    input  logic                clr_vld,
    input  logic [IDX_W-1:0]    clr_idx,
    output logic                pkt_vld_out,
    output logic [DATA_W-1:0]   pkt_data_out,
    output logic [ACTION_W-1:0] action_out,
    output logic [STATE_W-1:0]  state_out
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam logic [ACTION_W-1:0] ACT_FWD  = ACTION_W'(16'h0001);
    localparam logic [ACTION_W-1:0] ACT_DROP = ACTION_W'(16'h0002);

    logic [STATE_W-1:0]  table_q [DEPTH];

    logic                s1_vld_q;
    logic [DATA_W-1:0]   s1_data_q;
    logic [IDX_W-1:0]    s1_idx_q;
    logic [STATE_W-1:0]  s1_cur_q;

    logic [IDX_W-1:0]    s1_idx_d;
    logic [STATE_W-1:0]  s1_cur_d;
    logic [STATE_W-1:0]  nxt_d;
    logic [ACTION_W-1:0] action_d;

    always_comb begin
        s1_idx_d = pkt_data_in[KEY_LSB +: IDX_W];

        if ((MODE == 0) && (s1_cur_q == '1)) begin
            nxt_d = s1_cur_q;
        end else begin
            nxt_d = s1_cur_q + STATE_W'(1);
        end

        action_d = (32'(nxt_d) <= THRESH) ? ACT_FWD : ACT_DROP;

        // Clear beats the in-flight write-back, which beats the stored table value.
        if (clr_vld && (clr_idx == s1_idx_d)) begin
            s1_cur_d = '0;
        end else if (s1_vld_q && (s1_idx_q == s1_idx_d)) begin
            s1_cur_d = nxt_d;
        end else begin
            s1_cur_d = table_q[s1_idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            s1_vld_q     <= 1'b0;
            s1_data_q    <= '0;
            s1_idx_q     <= '0;
            s1_cur_q     <= '0;
            pkt_vld_out  <= 1'b0;
            pkt_data_out <= '0;
            action_out   <= '0;
            state_out    <= '0;
        end else begin
            s1_vld_q  <= pkt_vld_in;
            s1_data_q <= pkt_data_in;
            s1_idx_q  <= s1_idx_d;
            s1_cur_q  <= s1_cur_d;

            pkt_vld_out <= s1_vld_q;
            if (s1_vld_q) begin
                pkt_data_out      <= s1_data_q;
                state_out         <= nxt_d;
                action_out        <= action_d;
                table_q[s1_idx_q] <= nxt_d;
            end
            // Placed after the write-back so a same-index clear overrides it.
            if (clr_vld) begin
                table_q[clr_idx] <= '0;
            end
        end
    end

endmodule
